product_hex_pager: RTL and testbench

//  Downstream consumer of the Mult32 64-bit product. Latches one product via a valid/ready

---
 rtl/mult_pkg.sv | 18 +
 rtl/page_timer.sv | 39 +++
 rtl/product_hex_pager.sv | 109 ++++++++++
 tb/tb_product_hex_pager.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier display path: pager state encoding,
// page geometry and the default auto-page divider.
package mult_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StShow = 1'b1
  } state_e;

  localparam int unsigned PAGE_BITS        = 8;
  localparam int unsigned DEFAULT_PAGE_DIV = 50_000_000;

  // Number of byte pages in a product of the given width.
  function automatic int unsigned num_pages(input int unsigned prod_w);
    return prod_w / PAGE_BITS;
  endfunction

endpackage

// File: rtl/page_timer.sv
// Free-running page divider: counts while enabled, raises a one-cycle tick on
// the last count and wraps; clr forces it back to zero.
module page_timer
  import mult_pkg::*;
#(
  parameter int unsigned PAGE_DIV = DEFAULT_PAGE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = $clog2(PAGE_DIV);
  localparam logic [CntW-1:0] LastCnt = CntW'(PAGE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/product_hex_pager.sv
// Latches one multiplier product and pages it, a byte at a time, onto the two
// hex digit drivers; pages advance on a timer tick or a manual step edge.
module product_hex_pager
  import mult_pkg::*;
#(
  parameter int unsigned PROD_W   = 64,
  parameter int unsigned PAGE_DIV = DEFAULT_PAGE_DIV,
  parameter bit          AUTO     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] product,
  output logic              prod_ready,
  input  logic              step,
  input  logic              hold,
  output logic [3:0]        nib_lo,
  output logic [3:0]        nib_hi,
  output logic [2:0]        page_idx,
  output logic              showing
);

  localparam int unsigned NumPages = num_pages(PROD_W);
  localparam logic [2:0]  LastPage = 3'(NumPages - 1);

  state_e            state_q, state_d;
  logic [PROD_W-1:0] latch_q, latch_d;
  logic [2:0]        page_q, page_d;
  logic              pass_done_q, pass_done_d;
  logic              step_q;

  logic       accept;
  logic       step_rise;
  logic       tick;
  logic       advance;
  logic       timer_en;
  logic       timer_clr;
  logic [7:0] cur_byte;

  // A new product is only taken once the current one has been shown in full.
  assign prod_ready = (state_q == StIdle) | pass_done_q;
  assign accept     = prod_valid & prod_ready;
  assign step_rise  = step & ~step_q;
  assign timer_en   = AUTO && (state_q == StShow) && !hold;
  // Step edge and timer tick on the same edge merge into a single advance.
  assign advance    = (state_q == StShow) & (step_rise | tick);
  assign timer_clr  = accept | advance | (state_q == StIdle);

  page_timer #(
    .PAGE_DIV (PAGE_DIV)
  ) u_page_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    latch_d     = latch_q;
    page_d      = page_q;
    pass_done_d = pass_done_q;
    if (accept) begin
      state_d     = StShow;
      latch_d     = product;
      page_d      = '0;
      pass_done_d = 1'b0;
    end else if (advance) begin
      if (page_q == LastPage) begin
        page_d      = '0;
        pass_done_d = 1'b1;
      end else begin
        page_d = page_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      latch_q     <= '0;
      page_q      <= '0;
      pass_done_q <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      latch_q     <= latch_d;
      page_q      <= page_d;
      pass_done_q <= pass_done_d;
      step_q      <= step;
    end
  end

  always_comb begin
    cur_byte = '0;
    for (int unsigned p = 0; p < NumPages; p++) begin
      if (page_q == 3'(p)) begin
        cur_byte = latch_q[p*PAGE_BITS +: PAGE_BITS];
      end
    end
  end

  assign showing  = (state_q == StShow);
  assign page_idx = page_q;
  assign nib_lo   = showing ? cur_byte[3:0] : 4'h0;
  assign nib_hi   = showing ? cur_byte[7:4] : 4'h0;

endmodule

// File: tb/tb_product_hex_pager.sv
// Directed bench for product_hex_pager: one auto-paging instance and one
// manual-only instance, both with a short page divider.
module tb_product_hex_pager;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_valid, a_ready, a_step, a_hold, a_showing;
  logic [63:0] a_product;
  logic [3:0]  a_lo, a_hi;
  logic [2:0]  a_page;

  logic        m_valid, m_ready, m_step, m_hold, m_showing;
  logic [63:0] m_product;
  logic [3:0]  m_lo, m_hi;
  logic [2:0]  m_page;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  product_hex_pager #(
    .PROD_W   (64),
    .PAGE_DIV (4),
    .AUTO     (1'b1)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (a_valid),
    .product    (a_product),
    .prod_ready (a_ready),
    .step       (a_step),
    .hold       (a_hold),
    .nib_lo     (a_lo),
    .nib_hi     (a_hi),
    .page_idx   (a_page),
    .showing    (a_showing)
  );

  product_hex_pager #(
    .PROD_W   (64),
    .PAGE_DIV (4),
    .AUTO     (1'b0)
  ) dut_m (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (m_valid),
    .product    (m_product),
    .prod_ready (m_ready),
    .step       (m_step),
    .hold       (m_hold),
    .nib_lo     (m_lo),
    .nib_hi     (m_hi),
    .page_idx   (m_page),
    .showing    (m_showing)
  );

  task automatic cy(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_product = '0; a_step = 1'b0; a_hold = 1'b0;
    m_valid = 1'b0; m_product = '0; m_step = 1'b0; m_hold = 1'b0;

    // 1: reset
    cy(2);
    rst = 1'b0;
    check("rst ready",   32'(a_ready),   32'd1);
    check("rst showing", 32'(a_showing), 32'd0);
    check("rst page",    32'(a_page),    32'd0);
    check("rst nibs",    32'({a_hi, a_lo}), 32'h00);
    check("rst m ready", 32'(m_ready),   32'd1);

    // 2: accept and auto paging
    a_product = 64'hFEDC_BA98_7654_3210;
    a_valid   = 1'b1;
    cy(1);
    a_valid = 1'b0;
    check("acc showing", 32'(a_showing), 32'd1);
    check("acc nibs",    32'({a_hi, a_lo}), 32'h10);
    check("acc ready",   32'(a_ready),   32'd0);
    for (int p = 1; p < 8; p++) begin
      cy(4);
      check("auto page", 32'(a_page), 32'(p));
      check("auto nibs", 32'({a_hi, a_lo}), 32'h10 + 32'(p) * 32'h22);
    end
    cy(4);
    check("wrap page",  32'(a_page),  32'd0);
    check("wrap nibs",  32'({a_hi, a_lo}), 32'h10);
    check("wrap ready", 32'(a_ready), 32'd1);

    // 3: new product, then an early offer held through the whole pass
    a_product = 64'h0123_4567_89AB_CDEF;
    a_valid   = 1'b1;
    cy(1);
    check("p2 nibs",  32'({a_hi, a_lo}), 32'hEF);
    check("p2 ready", 32'(a_ready), 32'd0);
    a_product = 64'h1122_3344_5566_7788;
    cy(1);
    check("early ready", 32'(a_ready), 32'd0);
    check("early latch", 32'({a_hi, a_lo}), 32'hEF);
    cy(3);
    check("early page1", 32'(a_page), 32'd1);
    check("early nibs1", 32'({a_hi, a_lo}), 32'hCD);
    cy(28);
    check("early wrap page",  32'(a_page), 32'd0);
    check("early wrap nibs",  32'({a_hi, a_lo}), 32'hEF);
    check("early wrap ready", 32'(a_ready), 32'd1);
    cy(1);
    a_valid = 1'b0;
    check("p3 page",  32'(a_page), 32'd0);
    check("p3 nibs",  32'({a_hi, a_lo}), 32'h88);
    check("p3 ready", 32'(a_ready), 32'd0);

    // 5: hold freezes the timer; step edge + tick gives a single advance
    a_hold = 1'b1;
    cy(20);
    check("hold page", 32'(a_page), 32'd0);
    a_hold = 1'b0;
    cy(3);
    a_step = 1'b1;
    cy(1);
    a_step = 1'b0;
    check("collide page", 32'(a_page), 32'd1);
    check("collide nibs", 32'({a_hi, a_lo}), 32'h77);
    cy(3);
    check("post collide page", 32'(a_page), 32'd1);
    cy(1);
    check("next tick page", 32'(a_page), 32'd2);
    cy(24);
    check("p3 wrap ready", 32'(a_ready), 32'd1);
    cy(3);
    a_product = 64'h0F1E_2D3C_4B5A_6978;
    a_valid   = 1'b1;
    cy(1);
    a_valid = 1'b0;
    check("acc+adv page", 32'(a_page), 32'd0);
    check("acc+adv nibs", 32'({a_hi, a_lo}), 32'h78);
    check("acc+adv ready", 32'(a_ready), 32'd0);

    // 6: reset mid-display
    cy(20);
    check("p4 page5", 32'(a_page), 32'd5);
    check("p4 nibs5", 32'({a_hi, a_lo}), 32'h2D);
    rst = 1'b1;
    cy(1);
    rst = 1'b0;
    check("mid rst ready",   32'(a_ready),   32'd1);
    check("mid rst showing", 32'(a_showing), 32'd0);
    check("mid rst page",    32'(a_page),    32'd0);
    check("mid rst nibs",    32'({a_hi, a_lo}), 32'h00);
    cy(5);
    check("idle stays", 32'(a_showing), 32'd0);

    // 4: manual-only instance
    m_product = 64'h0123_4567_89AB_CDEF;
    m_valid   = 1'b1;
    cy(1);
    m_valid = 1'b0;
    check("m acc nibs", 32'({m_hi, m_lo}), 32'hEF);
    cy(10);
    check("m no auto", 32'(m_page), 32'd0);
    m_step = 1'b1;
    cy(10);
    m_step = 1'b0;
    check("m level page", 32'(m_page), 32'd1);
    check("m level nibs", 32'({m_hi, m_lo}), 32'hCD);
    cy(1);
    for (int i = 0; i < 6; i++) begin
      m_step = 1'b1;
      cy(1);
      m_step = 1'b0;
      cy(1);
    end
    check("m page7",  32'(m_page), 32'd7);
    check("m nibs7",  32'({m_hi, m_lo}), 32'h01);
    check("m ready7", 32'(m_ready), 32'd0);
    m_step = 1'b1;
    cy(1);
    m_step = 1'b0;
    check("m wrap page",  32'(m_page), 32'd0);
    check("m wrap nibs",  32'({m_hi, m_lo}), 32'hEF);
    check("m wrap ready", 32'(m_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
